traffic_analyzer_gmii: RTL and testbench
========================================

// Module: traffic_analyzer_gmii
// PURPOSE
//  GMII receive-side counterpart of the traffic generator: monitors an 8-bit GMII stream, strips preamble/SFD,
//  checks CRC-32 FCS and length, classifies each frame and keeps saturating statistics plus SFD timestamp and
//  inter-frame gap. Sits on the loopback/RX path of the tester; counters feed the CPU register block.
// PARAMETERS
//  MIN_FRAME   64    min legal length (bytes after SFD, incl. FCS)
//  MAX_FRAME   1518  max legal length (bytes after SFD, incl. FCS)
//  CNT_WIDTH   32    width of every frame counter
// PORTS
//  clk             in   1     GMII RX clock, all logic on rising edge
//  rst             in   1     asynchronous, active-high reset
//  gmii_d          in   8     RX data
//  gmii_en         in   1     RX data valid
//  gmii_er         in   1     RX error
//  sec             in   48    time-of-day seconds
//  nsec            in   30    time-of-day nanoseconds
//  enable          in   1     1 = accept new frames
//  clear           in   1     sync pulse: zero all statistics
//  frame_done      out  1     1-cycle pulse when a frame is classified
//  frames_good     out  CNT_WIDTH
//  frames_crc_err  out  CNT_WIDTH
//  frames_gmii_err out  CNT_WIDTH   frames with gmii_er seen during DATA
//  frames_runt     out  CNT_WIDTH
//  frames_oversize out  CNT_WIDTH
//  frames_align_err out CNT_WIDTH   bad/missing preamble or SFD
//  bytes_good      out  48    sum of lengths of good frames
//  last_len        out  16    length of last classified frame (saturates 0xFFFF)
//  last_sec        out  48    sec latched at SFD of last classified frame
//  last_nsec       out  30    nsec latched at SFD of last classified frame
//  last_ifg        out  32    gmii_en=0 cycles preceding last frame start (saturating)
// BEHAVIOUR
//  Reset: all outputs/counters 0, state IDLE, en_d (registered gmii_en) resets to 1 so a frame in progress at
//   reset release is not treated as a start.
//  Start = enable & gmii_en & ~en_d, only in IDLE. IFG counter counts gmii_en=0 cycles, latched to last_ifg at start.
//  FSM:
//   IDLE: start & d==0x55 -> PRE; start & d!=0x55 -> DROP (align err pending).
//   PRE:  en & d==0x55 -> PRE; en & d==0xD5 -> DATA, latch sec/nsec, CRC=0xFFFFFFFF, len=0;
//         en & other -> DROP (align); en=0 -> IDLE, classify align err.
//   DATA: en: len+=1 (sat), CRC update (reflected poly 0xEDB88320, LSB first), er -> err flag; en=0 -> IDLE, classify.
//   DROP: wait for en=0 -> IDLE, classify align err. Data ignored.
//  Classification priority: align > gmii_err > runt (len<MIN) > oversize (len>MAX) > CRC (register != 0xDEBB20E3) > good.
//   Exactly one counter +1 per frame; good also adds len to bytes_good.
//  Latency: frame_done, counters, last_* update 1 cycle after the first cycle with gmii_en=0.
//  enable=0 mid-frame: current frame completes and is counted; no new start.
//  All counters saturate at all-ones. clear same cycle as an update: clear wins (result 0, update lost).
//  Async rst mid-frame: everything cleared; remainder of that frame ignored (en_d=1), not counted.
// TESTING
//  1. 7x0x55,0xD5, 60 payload + valid FCS, enable=1 -> frames_good=1, bytes_good=64, last_len=64, frame_done 1 cycle after en falls.
//  2. Same frame, FCS bit0 flipped -> frames_crc_err=1, frames_good=0, bytes_good=0.
//  3. Valid frame with gmii_er=1 on byte 20 -> frames_gmii_err=1 only; 56+4 byte valid-CRC frame -> frames_runt=1; 1519 bytes -> frames_oversize=1.
//  4. 0x55,0x55,0x00 then data -> frames_align_err=1; 12 idle cycles between two good frames -> last_ifg=12, last_sec/nsec = values at 2nd SFD.
//  5. clear coincident with frame_done of good frame -> all counters 0; rst asserted on byte 30 -> no counter change, next frame counted good.
//  6. Force frames_good=2^32-1 (or CNT_WIDTH=4, 16 good frames) -> counter holds 0xF, no wrap.

Source files
------------

// File: rtl/traffic_analyzer_gmii_if.sv
// rtl/traffic_analyzer_gmii_if.sv - GMII receive bus bundle
interface traffic_analyzer_gmii_if;
  logic [7:0] gmii_d;
  logic       gmii_en;
  logic       gmii_er;

  modport master (output gmii_d, output gmii_en, output gmii_er);
  modport slave  (input  gmii_d, input  gmii_en, input  gmii_er);
endinterface

// File: rtl/traffic_analyzer_gmii.sv
// rtl/traffic_analyzer_gmii.sv - GMII RX frame checker: preamble/SFD strip, FCS/length
// classification, saturating statistics, SFD timestamp and inter-frame gap
module traffic_analyzer_gmii #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_analyzer_gmii_if.slave i_gmii,
  input  logic [47:0]            i_sec,
  input  logic [29:0]            i_nsec,
  input  logic                   i_enable,
  input  logic                   i_clear,
  output logic                   o_frame_done,
  output logic [CNT_WIDTH-1:0]   o_frames_good,
  output logic [CNT_WIDTH-1:0]   o_frames_crc_err,
  output logic [CNT_WIDTH-1:0]   o_frames_gmii_err,
  output logic [CNT_WIDTH-1:0]   o_frames_runt,
  output logic [CNT_WIDTH-1:0]   o_frames_oversize,
  output logic [CNT_WIDTH-1:0]   o_frames_align_err,
  output logic [47:0]            o_bytes_good,
  output logic [15:0]            o_last_len,
  output logic [47:0]            o_last_sec,
  output logic [29:0]            o_last_nsec,
  output logic [31:0]            o_last_ifg
);
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      r_state, w_next;
  logic        r_en_d;
  logic [31:0] r_crc;
  logic [15:0] r_len;
  logic        r_gerr;
  logic [31:0] r_ifg, r_ifg_pend;
  logic [47:0] r_sec_pend;
  logic [29:0] r_nsec_pend;
  logic        w_start, w_sfd, w_done, w_align;
  logic [31:0] w_crc_next;
  logic [48:0] w_bytes_sum;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_start     = (r_state == S_IDLE) & i_enable & i_gmii.gmii_en & ~r_en_d;
  assign w_bytes_sum = {1'b0, o_bytes_good} + {33'h0, r_len};

  // Reflected CRC-32, one byte per clock, LSB first
  always_comb begin
    w_crc_next = r_crc ^ {24'h0, i_gmii.gmii_d};
    for (int b = 0; b < 8; b++)
      w_crc_next = w_crc_next[0] ? ((w_crc_next >> 1) ^ 32'hEDB88320) : (w_crc_next >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_sfd   = 1'b0;
    w_done  = 1'b0;
    w_align = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = (i_gmii.gmii_d == 8'h55) ? S_PRE : S_DROP;
      S_PRE: begin
        if (!i_gmii.gmii_en) begin
          w_next  = S_IDLE;
          w_done  = 1'b1;
          w_align = 1'b1;
        end else if (i_gmii.gmii_d == 8'hD5) begin
          w_next = S_DATA;
          w_sfd  = 1'b1;
        end else if (i_gmii.gmii_d != 8'h55) begin
          w_next = S_DROP;
        end
      end
      S_DATA: if (!i_gmii.gmii_en) begin
        w_next = S_IDLE;
        w_done = 1'b1;
      end
      S_DROP: if (!i_gmii.gmii_en) begin
        w_next  = S_IDLE;
        w_done  = 1'b1;
        w_align = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // en_d resets high so a frame already running when reset lifts is never a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d       <= 1'b1;
      r_crc        <= '1;
      r_len        <= '0;
      r_gerr       <= 1'b0;
      r_ifg        <= '0;
      r_ifg_pend   <= '0;
      r_sec_pend   <= '0;
      r_nsec_pend  <= '0;
      o_frame_done <= 1'b0;
      o_last_len   <= '0;
      o_last_sec   <= '0;
      o_last_nsec  <= '0;
      o_last_ifg   <= '0;
    end else begin
      r_en_d       <= i_gmii.gmii_en;
      o_frame_done <= w_done;
      if (w_start) begin
        r_ifg_pend <= r_ifg;
        r_ifg      <= '0;
      end else if (!i_gmii.gmii_en && r_ifg != '1) begin
        r_ifg <= r_ifg + 32'd1;
      end
      if (w_sfd) begin
        r_sec_pend  <= i_sec;
        r_nsec_pend <= i_nsec;
        r_crc       <= '1;
        r_len       <= '0;
        r_gerr      <= 1'b0;
      end else if (r_state == S_DATA && i_gmii.gmii_en) begin
        r_crc <= w_crc_next;
        if (r_len != '1)       r_len  <= r_len + 16'd1;
        if (i_gmii.gmii_er)    r_gerr <= 1'b1;
      end
      if (w_done) begin
        o_last_len  <= w_align ? 16'h0 : r_len;
        o_last_sec  <= r_sec_pend;
        o_last_nsec <= r_nsec_pend;
        o_last_ifg  <= r_ifg_pend;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clear) begin
      o_frames_good      <= '0;
      o_frames_crc_err   <= '0;
      o_frames_gmii_err  <= '0;
      o_frames_runt      <= '0;
      o_frames_oversize  <= '0;
      o_frames_align_err <= '0;
      o_bytes_good       <= '0;
    end else if (w_done) begin
      if (w_align)                   o_frames_align_err <= sat_inc(o_frames_align_err);
      else if (r_gerr)               o_frames_gmii_err  <= sat_inc(o_frames_gmii_err);
      else if (r_len < MIN_LEN)      o_frames_runt      <= sat_inc(o_frames_runt);
      else if (r_len > MAX_LEN)      o_frames_oversize  <= sat_inc(o_frames_oversize);
      else if (r_crc != CRC_RESIDUE) o_frames_crc_err   <= sat_inc(o_frames_crc_err);
      else begin
        o_frames_good <= sat_inc(o_frames_good);
        o_bytes_good  <= w_bytes_sum[48] ? '1 : w_bytes_sum[47:0];
      end
    end
  end
endmodule

// File: tb/tb_traffic_analyzer_gmii.sv
// tb/tb_traffic_analyzer_gmii.sv - directed and randomized frames against a frame-level model
module tb_traffic_analyzer_gmii;
  localparam int CW = 4;
  typedef logic [7:0] u8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] sec = 48'h0;
  logic [29:0] nsec = 30'h0;
  logic        en_in = 1'b1;
  logic        clr = 1'b0;

  traffic_analyzer_gmii_if gif();

  logic          o_done;
  logic [CW-1:0] o_good, o_crc, o_gerr, o_runt, o_over, o_align;
  logic [47:0]   o_bytes, o_lsec;
  logic [15:0]   o_llen;
  logic [29:0]   o_lnsec;
  logic [31:0]   o_lifg;

  traffic_analyzer_gmii #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_gmii(gif), .i_sec(sec), .i_nsec(nsec),
    .i_enable(en_in), .i_clear(clr), .o_frame_done(o_done),
    .o_frames_good(o_good), .o_frames_crc_err(o_crc), .o_frames_gmii_err(o_gerr),
    .o_frames_runt(o_runt), .o_frames_oversize(o_over), .o_frames_align_err(o_align),
    .o_bytes_good(o_bytes), .o_last_len(o_llen), .o_last_sec(o_lsec),
    .o_last_nsec(o_lnsec), .o_last_ifg(o_lifg)
  );

  always #4 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input u8 q[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame-level model: collect each burst, then classify it as a whole
  u8           m_b[$];
  logic        m_e[$];
  logic [47:0] m_s[$];
  logic [29:0] m_n[$];
  logic        m_prev_en, m_in;
  logic [31:0] m_ifg, m_ifg_start;
  logic [47:0] m_sec_pend;
  logic [29:0] m_nsec_pend;
  logic          x_done;
  logic [CW-1:0] x_cnt [6];
  logic [47:0]   x_bytes, x_lsec;
  logic [15:0]   x_llen;
  logic [29:0]   x_lnsec;
  logic [31:0]   x_lifg;

  task automatic m_reset();
    m_b.delete(); m_e.delete(); m_s.delete(); m_n.delete();
    m_prev_en = 1'b1; m_in = 1'b0; m_ifg = '0; m_ifg_start = '0;
    m_sec_pend = '0; m_nsec_pend = '0;
    x_done = 1'b0; x_bytes = '0; x_llen = '0; x_lsec = '0; x_lnsec = '0; x_lifg = '0;
    for (int i = 0; i < 6; i++) x_cnt[i] = '0;
  endtask

  // cls: 0 good, 1 crc, 2 oversize, 3 runt, 4 gmii_err, 5 align
  task automatic m_classify(output int cls, output int len);
    int k, i;
    u8 d[$];
    logic gerr;
    logic [31:0] fcs;
    k = m_b.size(); i = 1; cls = 5; len = 0;
    if (m_b[0] == 8'h55) begin
      while (i < k && m_b[i] == 8'h55) i++;
      if (i < k && m_b[i] == 8'hD5) begin
        m_sec_pend = m_s[i]; m_nsec_pend = m_n[i];
        len = (k - 1 - i > 65535) ? 65535 : k - 1 - i;
        gerr = 1'b0;
        for (int j = i + 1; j < k; j++) begin
          d.push_back(m_b[j]);
          gerr = gerr | m_e[j];
        end
        if (gerr)            cls = 4;
        else if (len < 64)   cls = 3;
        else if (len > 1518) cls = 2;
        else begin
          fcs = {d[len-1], d[len-2], d[len-3], d[len-4]};
          cls = (crc32(d, len - 4) == fcs) ? 0 : 1;
        end
      end
    end
  endtask

  initial begin
    int cls, len;
    logic [48:0] s;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        x_done = 1'b0; cls = 0; len = 0;
        if (m_in) begin
          if (gif.gmii_en) begin
            m_b.push_back(gif.gmii_d); m_e.push_back(gif.gmii_er);
            m_s.push_back(sec); m_n.push_back(nsec);
          end else begin
            m_classify(cls, len);
            x_done = 1'b1; m_in = 1'b0;
          end
        end else if (en_in && gif.gmii_en && !m_prev_en) begin
          m_in = 1'b1;
          m_b = {gif.gmii_d}; m_e = {gif.gmii_er}; m_s = {sec}; m_n = {nsec};
          m_ifg_start = m_ifg; m_ifg = '0;
        end
        if (!gif.gmii_en && m_ifg != 32'hFFFFFFFF) m_ifg = m_ifg + 1;
        if (x_done) begin
          x_llen = 16'(len); x_lsec = m_sec_pend; x_lnsec = m_nsec_pend; x_lifg = m_ifg_start;
        end
        if (clr) begin
          for (int i = 0; i < 6; i++) x_cnt[i] = '0;
          x_bytes = '0;
        end else if (x_done) begin
          if (x_cnt[cls] != '1) x_cnt[cls] = x_cnt[cls] + 1'b1;
          if (cls == 0) begin
            s = {1'b0, x_bytes} + 49'(len);
            x_bytes = s[48] ? '1 : s[47:0];
          end
        end
        m_prev_en = gif.gmii_en;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp("frame_done", o_done, x_done);
      cmp("frames_good", o_good, x_cnt[0]);
      cmp("frames_crc_err", o_crc, x_cnt[1]);
      cmp("frames_oversize", o_over, x_cnt[2]);
      cmp("frames_runt", o_runt, x_cnt[3]);
      cmp("frames_gmii_err", o_gerr, x_cnt[4]);
      cmp("frames_align_err", o_align, x_cnt[5]);
      cmp("bytes_good", o_bytes, x_bytes);
      cmp("last_len", o_llen, x_llen);
      cmp("last_sec", o_lsec, x_lsec);
      cmp("last_nsec", o_lnsec, x_lnsec);
      cmp("last_ifg", o_lifg, x_lifg);
    end
  end

  u8           fq[$];
  logic [47:0] sfd_sec;
  logic [29:0] sfd_nsec;

  task automatic cyc(input u8 d, input logic en, input logic er, input logic c, input logic r);
    @(posedge clk); #1;
    gif.gmii_d = d; gif.gmii_en = en; gif.gmii_er = er;
    clr = c; rst = r;
    sec = sec + 48'd1; nsec = 30'($urandom);
  endtask

  task automatic mk(input int npre, input int plen, input logic bad);
    u8 p[$];
    logic [31:0] f;
    fq.delete();
    repeat (npre) fq.push_back(8'h55);
    fq.push_back(8'hD5);
    for (int j = 0; j < plen; j++) p.push_back(u8'($urandom));
    f = crc32(p, plen);
    if (bad) f[0] = ~f[0];
    foreach (p[j]) fq.push_back(p[j]);
    fq.push_back(f[7:0]); fq.push_back(f[15:8]); fq.push_back(f[23:16]); fq.push_back(f[31:24]);
  endtask

  task automatic send(input int er_at, input int rst_at, input int en_off_at, input int gap,
                      input logic clr_first);
    for (int j = 0; j < fq.size(); j++) begin
      cyc(fq[j], 1'b1, j == er_at, 1'b0, j == rst_at);
      if (j == 7) begin sfd_sec = sec; sfd_nsec = nsec; end
      if (j == en_off_at) en_in = 1'b0;
    end
    for (int j = 0; j < gap; j++) cyc(8'h00, 1'b0, 1'b0, clr_first && j == 0, 1'b0);
  endtask

  task automatic clear_stats();
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    logic [47:0] s2;
    logic [29:0] n2;
    gif.gmii_d = 8'h00; gif.gmii_en = 1'b0; gif.gmii_er = 1'b0;
    repeat (3) @(posedge clk);
    repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmp("rst_good", o_good, 0); cmp("rst_bytes", o_bytes, 0); cmp("rst_done", o_done, 0);

    mk(7, 60, 1'b0); send(-1, -1, -1, 0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); cmp("t1_done_early", o_done, 0);
    @(negedge clk); cmp("t1_done", o_done, 1);
    repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmp("t1_good", o_good, 1); cmp("t1_bytes", o_bytes, 64); cmp("t1_len", o_llen, 64);

    clear_stats();
    mk(7, 60, 1'b1); send(-1, -1, -1, 4, 1'b0);
    @(negedge clk);
    cmp("t2_crc", o_crc, 1); cmp("t2_good", o_good, 0); cmp("t2_bytes", o_bytes, 0);

    clear_stats();
    mk(7, 60, 1'b0);   send(28, -1, -1, 4, 1'b0);
    mk(7, 56, 1'b0);   send(-1, -1, -1, 4, 1'b0);
    mk(7, 1515, 1'b0); send(-1, -1, -1, 4, 1'b0);
    mk(7, 59, 1'b0);   send(-1, -1, -1, 4, 1'b0);
    mk(7, 1514, 1'b0); send(-1, -1, -1, 4, 1'b0);
    @(negedge clk);
    cmp("t3_gerr", o_gerr, 1); cmp("t3_runt", o_runt, 2); cmp("t3_over", o_over, 1);
    cmp("t3_good", o_good, 1); cmp("t3_len1518", o_llen, 1518); cmp("t3_crc", o_crc, 0);

    clear_stats();
    fq = {8'h55, 8'h55, 8'h00};
    for (int j = 0; j < 70; j++) fq.push_back(u8'($urandom));
    send(-1, -1, -1, 4, 1'b0);
    mk(7, 60, 1'b0); send(-1, -1, -1, 12, 1'b0);
    mk(7, 70, 1'b0); send(-1, -1, -1, 0, 1'b0);
    s2 = sfd_sec; n2 = sfd_nsec;
    repeat (4) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmp("t4_align", o_align, 1); cmp("t4_ifg", o_lifg, 12); cmp("t4_good", o_good, 2);
    cmp("t4_sec", o_lsec, s2); cmp("t4_nsec", o_lnsec, n2); cmp("t4_bytes", o_bytes, 138);

    mk(7, 60, 1'b0); send(-1, -1, -1, 4, 1'b1);
    @(negedge clk);
    cmp("t5_clr_good", o_good, 0); cmp("t5_clr_bytes", o_bytes, 0); cmp("t5_clr_align", o_align, 0);
    mk(7, 60, 1'b0); send(-1, 30, -1, 4, 1'b0);
    @(negedge clk); cmp("t5_rst_good", o_good, 0); cmp("t5_rst_crc", o_crc, 0);
    mk(7, 60, 1'b0); send(-1, -1, -1, 4, 1'b0);
    @(negedge clk); cmp("t5_after_rst", o_good, 1);

    clear_stats();
    mk(7, 60, 1'b0); send(-1, -1, 10, 4, 1'b0);
    mk(7, 60, 1'b0); send(-1, -1, -1, 4, 1'b0);
    en_in = 1'b1;
    @(negedge clk); cmp("t_enable_good", o_good, 1);

    clear_stats();
    repeat (16) begin mk(7, 60, 1'b0); send(-1, -1, -1, 3, 1'b0); end
    @(negedge clk);
    cmp("t6_sat", o_good, 15); cmp("t6_bytes", o_bytes, 1024);

    for (int it = 0; it < 40; it++) begin
      int np, pl, idx, er_at, off_at, rst_at;
      np = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 7;
      pl = ($urandom_range(0, 9) == 0) ? $urandom_range(1505, 1518) : $urandom_range(40, 80);
      mk(np, pl, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, fq.size() - 1);
        fq[idx] = fq[idx] ^ 8'h5A;
      end
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(1, 6);
        while (fq.size() > idx) void'(fq.pop_back());
      end
      er_at  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, fq.size() - 1) : -1;
      off_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, fq.size() - 1) : -1;
      rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(0, fq.size() - 1) : -1;
      en_in = ($urandom_range(0, 7) != 0);
      send(er_at, rst_at, off_at, $urandom_range(1, 15), $urandom_range(0, 9) == 0);
      en_in = 1'b1;
    end

    repeat (5) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
